// File: rtl/cache_controller_pkg.sv
// Shared definitions for the cache controller slice.
//  - cc_state_e : controller sequencing states
//  - DEF_*      : default geometry used by the top-level parameters
//  - tag_bits() : tag width derived from address and index widths
package cache_controller_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_INDEX_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a CPU request
    MRD  = 2'd1,  // read miss: RAM read in flight
    MWR  = 2'd2,  // write-through: RAM write in flight
    RESP = 2'd3   // one-cycle completion to the CPU
  } cc_state_e;

  // Everything above the index is tag; one word per line, so no offset field.
  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line store: valid bits, tags and one data word per line.
//  clock, reset_n            : clock, async active-low reset (clears valid only)
//  lookup_addr               : word address to look up (combinational)
//  lookup_hit, lookup_data   : valid-and-tag-match, and the stored word
//  wr_en, wr_addr, wr_data   : single synchronous write port; sets the line's
//                              tag from wr_addr, stores wr_data, marks it valid
module cache_line_store
  import cache_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS);

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] lk_index, wr_index;
  logic [TAG_BITS-1:0]   lk_tag, wr_tag;

  assign lk_index = lookup_addr[INDEX_BITS-1:0];
  assign lk_tag   = lookup_addr[ADDR_WIDTH-1:INDEX_BITS];
  assign wr_index = wr_addr[INDEX_BITS-1:0];
  assign wr_tag   = wr_addr[ADDR_WIDTH-1:INDEX_BITS];

  assign lookup_hit  = valid_q[lk_index] && (tag_mem[lk_index] == lk_tag);
  assign lookup_data = data_mem[lk_index];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays have no reset; the valid bits alone make stale
  // contents invisible, and leaving them unreset lets them map to plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Accepts one CPU request at a time; read hits are served from the line store,
// read misses fill from RAM, and every write goes through to RAM.
//  clock, reset_n                      : clock, async active-low reset
//  cpu_req/cpu_wr/cpu_addr/cpu_wdata   : CPU request (sampled only in IDLE)
//  cpu_ready/cpu_rdata/cpu_hit         : one-cycle completion, read data, hit flag
//  mem_req/mem_wr/mem_addr/mem_wdata   : RAM request, held until mem_ack
//  mem_ack/mem_rdata                   : RAM completion, read data same cycle
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_hit,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  cc_state_e state;

  logic                  lookup_hit;
  logic [DATA_WIDTH-1:0] lookup_data;
  logic                  line_wr_en;
  logic [ADDR_WIDTH-1:0] line_wr_addr;
  logic [DATA_WIDTH-1:0] line_wr_data;

  // Lookup always uses the live CPU address: it only matters in the IDLE
  // acceptance cycle, so no extra latch stage is needed for hit detection.
  cache_line_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_line_store (
    .clock       (clock),
    .reset_n     (reset_n),
    .lookup_addr (cpu_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .wr_en       (line_wr_en),
    .wr_addr     (line_wr_addr),
    .wr_data     (line_wr_data)
  );

  // Line write port: write hits update in the acceptance cycle; read misses
  // fill from RAM on ack using the latched address held in mem_addr.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    line_wr_en   = 1'b0;
    line_wr_addr = cpu_addr;
    line_wr_data = cpu_wdata;
    case (state)
      IDLE: line_wr_en = cpu_req && cpu_wr && lookup_hit;
      MRD: begin
        line_wr_en   = mem_ack;
        line_wr_addr = mem_addr;
        line_wr_data = mem_rdata;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (!cpu_wr && lookup_hit) begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_hit   <= 1'b1;
              cpu_rdata <= lookup_data;
            end else begin
              // mem_addr/mem_wdata double as the latched request operands.
              state     <= cpu_wr ? MWR : MRD;
              mem_req   <= 1'b1;
              mem_wr    <= cpu_wr;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        MRD: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            cpu_rdata <= mem_rdata;
            cpu_hit   <= 1'b0;
            cpu_ready <= 1'b1;
          end
        end
        MWR: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_ready <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
          cpu_hit   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus pushes expected CPU
// responses and RAM transactions; a monitor and a RAM responder pop/compare.
module tb_cache_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  cache_controller dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        check_rdata;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  resp_t    exp_resp_q[$];
  mem_txn_t exp_mem_q[$];

  int checks = 0;
  int failures = 0;

  // RAM responder controls
  int          ack_delay = 1;
  logic [31:0] ram_data = '0;
  logic        force_ack = 1'b0;
  int          req_cycles = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && cpu_ready) begin
        if (exp_resp_q.size() == 0) begin
          check("spurious_cpu_ready", 32'(cpu_ready), 32'd0);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_hit", 32'(cpu_hit), 32'(e.hit));
          if (e.check_rdata) check("resp_rdata", cpu_rdata, e.rdata);
        end
      end
    end
  end

  // RAM responder: acks in the ack_delay-th cycle mem_req is high.
  initial begin
    mem_txn_t t;
    forever begin
      @(negedge clock);
      if (mem_req) begin
        if (req_cycles == 0) begin
          if (exp_mem_q.size() == 0) begin
            check("unexpected_mem_req", 32'(mem_req), 32'd0);
          end else begin
            t = exp_mem_q.pop_front();
            check("mem_wr", 32'(mem_wr), 32'(t.wr));
            check("mem_addr", mem_addr, t.addr);
            if (t.wr) check("mem_wdata", mem_wdata, t.wdata);
          end
        end
        req_cycles++;
        mem_ack   = (req_cycles == ack_delay);
        mem_rdata = mem_ack ? ram_data : 32'h0;
      end else begin
        if (req_cycles > 0 && reset_n)
          check("mem_req_hold_cycles", 32'(req_cycles), 32'(ack_delay));
        req_cycles = 0;
        mem_ack    = force_ack;
        mem_rdata  = '0;
      end
    end
  end

  // Issue one request, hold cpu_req until cpu_ready, check latency.
  task automatic do_req(input string name, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic uses_mem, input int delay,
                        input logic [31:0] rdata_from_ram,
                        input logic exp_hit, input logic [31:0] exp_rdata,
                        input int exp_lat);
    int cyc;
    @(negedge clock);
    ack_delay = delay;
    ram_data  = rdata_from_ram;
    if (uses_mem) exp_mem_q.push_back('{wr, addr, wdata});
    exp_resp_q.push_back('{exp_rdata, exp_hit, !wr});
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!cpu_ready && cyc < 50);
    check({"latency_", name}, 32'(cyc), 32'(exp_lat));
    cpu_req   = 1'b0;
    cpu_addr  = 32'hFFFF_FFFF;  // operand churn after completion must not matter
    cpu_wdata = 32'h0BAD_0BAD;
  endtask

  initial begin
    int cyc;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    // Reset state
    #12;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_hit", 32'(cpu_hit), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1. Cold read miss, ack in 3rd cycle of mem_req
    do_req("cold_read", 1'b0, 32'h23, 32'h0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4);
    // 2. Read hit
    do_req("read_hit", 1'b0, 32'h23, 32'h0, 1'b0, 1, 32'h0, 1'b1, 32'hDEADBEEF, 1);
    // 3. Conflict on index 3, then original address misses again (ack in first cycle)
    do_req("conflict_fill", 1'b0, 32'h43, 32'h0, 1'b1, 2, 32'h12345678, 1'b0, 32'h12345678, 3);
    do_req("conflict_refill", 1'b0, 32'h23, 32'h0, 1'b1, 1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2);
    // 4. Write-through hit, then read hit with new data
    do_req("write_hit", 1'b1, 32'h23, 32'hCAFEF00D, 1'b1, 2, 32'h0, 1'b0, 32'h0, 3);
    do_req("read_after_write", 1'b0, 32'h23, 32'h0, 1'b0, 1, 32'h0, 1'b1, 32'hCAFEF00D, 1);
    // 5. Write miss: no allocation, later read misses
    do_req("write_miss", 1'b1, 32'h05, 32'h00000011, 1'b1, 3, 32'h0, 1'b0, 32'h0, 4);
    do_req("read_no_alloc", 1'b0, 32'h05, 32'h0, 1'b1, 2, 32'h00000011, 1'b0, 32'h00000011, 3);

    // Stray mem_ack while idle is ignored
    @(negedge clock);
    force_ack = 1'b1;
    repeat (3) @(negedge clock);
    force_ack = 1'b0;
    do_req("hit_after_stray_ack", 1'b0, 32'h23, 32'h0, 1'b0, 1, 32'h0, 1'b1, 32'hCAFEF00D, 1);

    // Back-to-back: held cpu_req gives two hits with one IDLE cycle between
    @(negedge clock);
    exp_resp_q.push_back('{32'hCAFEF00D, 1'b1, 1'b1});
    exp_resp_q.push_back('{32'hCAFEF00D, 1'b1, 1'b1});
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 32'h23;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!cpu_ready && cyc < 50);
    check("b2b_first_latency", 32'(cyc), 32'd1);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!cpu_ready && cyc < 50);
    check("b2b_second_gap", 32'(cyc), 32'd2);
    cpu_req = 1'b0;

    // 6. Reset abort during MRD
    @(negedge clock);
    ack_delay = 10;
    exp_mem_q.push_back('{1'b0, 32'h43, 32'h0});
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 32'h43;
    repeat (2) @(negedge clock);
    check("abort_mem_req_before", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_mem_req_dropped", 32'(mem_req), 32'd0);
    check("abort_no_ready", 32'(cpu_ready), 32'd0);
    check("abort_mem_wr", 32'(mem_wr), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_still_no_ready", 32'(cpu_ready), 32'd0);
    reset_n = 1'b1;
    // Previously cached 0x23 now misses
    do_req("miss_after_reset", 1'b0, 32'h23, 32'h0, 1'b1, 1, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 2);

    repeat (3) @(negedge clock);
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
